// File: rtl/i2s_pp_pkg.sv
// Shared constants and types for the I2S ping-pong capture block.
package i2s_pp_pkg;

   localparam int SLOT_BITS = 32;
   localparam int DATA_BITS = 24;

   typedef logic signed [DATA_BITS-1:0] sample_t;

   typedef enum logic {BANK0 = 1'b0, BANK1 = 1'b1} bank_t;

   typedef enum logic {RD_IDLE = 1'b0, RD_BUSY = 1'b1} rd_state_t;

   function automatic bank_t other_bank(input bank_t b);
      return (b == BANK0) ? BANK1 : BANK0;
   endfunction

endpackage

// File: rtl/sp_ram_bank.sv
// Single-port RAM bank with a registered read port; one access per cycle.
module sp_ram_bank #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 512,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: the storage array is deliberately left without reset so it maps onto block RAM.
   always_ff @(posedge clk_i) begin
      if (en && we) mem[addr] <= wdata;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)         rdata <= '0;
      else if (en && !we)  rdata <= mem[addr];
   end

endmodule

// File: rtl/i2s_pingpong_capture.sv
// I2S receiver with SCK/WS generation and ping-pong RAM capture of left samples.
// Define I2S_PP_SAT_ROUND_EN to round-and-saturate the stored word instead of truncating.
module i2s_pingpong_capture
   import i2s_pp_pkg::*;
#(
   parameter int SCK_DIV = 4,
   parameter int WIDTH   = 16,
   parameter int DEPTH   = 512
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             sd_i,
   output logic             sck_o,
   output logic             ws_o,
   output logic             frame_start_o,
   output logic [23:0]      left_o,
   output logic [23:0]      right_o,
   output logic             ready_o,
   output logic [WIDTH-1:0] read_data_o,
   output logic             buffer_ready_o
);

   localparam int DIV_W = $clog2(SCK_DIV);
   localparam int AW    = $clog2(DEPTH);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
   localparam logic [AW-1:0]    PTR_LAST = AW'(DEPTH - 1);

   logic [DIV_W-1:0]     div_cnt;
   logic [5:0]           slot;
   logic                 sck_rise, in_data, is_lsb, armed;
   logic [DATA_BITS-2:0] shift_q;
   sample_t              rx_word, left_hold;
   logic [WIDTH-1:0]     ram_word;

   assign sck_rise = (div_cnt == DIV_LAST) && !sck_o;
   assign ws_o     = slot[5];
   assign in_data  = (slot[4:0] != 5'd0) && (slot[4:0] <= 5'(DATA_BITS));
   assign is_lsb   = (slot[4:0] == 5'(DATA_BITS));
   assign rx_word  = {shift_q, sd_i};

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_cnt       <= '0;
         sck_o         <= 1'b0;
         slot          <= '0;
         frame_start_o <= 1'b0;
      end else begin
         frame_start_o <= 1'b0;
         if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            sck_o   <= ~sck_o;
            if (sck_o) begin
               slot          <= slot + 6'd1;
               frame_start_o <= (slot == 6'(2 * SLOT_BITS - 1));
            end
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

   // Nothing is published until a whole frame has been seen after reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         armed     <= 1'b0;
         shift_q   <= '0;
         left_hold <= '0;
         left_o    <= '0;
         right_o   <= '0;
         ready_o   <= 1'b0;
      end else begin
         ready_o <= 1'b0;
         if (frame_start_o) armed <= 1'b1;
         if (sck_rise && in_data) begin
            shift_q <= rx_word[DATA_BITS-2:0];
            if (is_lsb && armed) begin
               if (!ws_o) begin
                  left_hold <= rx_word;
               end else begin
                  left_o  <= left_hold;
                  right_o <= rx_word;
                  ready_o <= 1'b1;
               end
            end
         end
      end
   end

`ifdef I2S_PP_SAT_ROUND_EN
   localparam int         RND_SH  = (WIDTH < DATA_BITS) ? DATA_BITS - 1 - WIDTH : 0;
   localparam logic [23:0] RND_INC = (WIDTH < DATA_BITS) ? (24'd1 << RND_SH) : 24'd0;
   logic [23:0] rounded;

   // NOTE: every always_comb assigns all its outputs on every path so no latch is inferred.
   always_comb begin
      rounded = left_o + RND_INC;
      if (!left_o[23] && rounded[23]) ram_word = {1'b0, {(WIDTH-1){1'b1}}};
      else                            ram_word = rounded[23 -: WIDTH];
   end
`else
   assign ram_word = left_o[23 -: WIDTH];
`endif

   bank_t            wr_bank, rd_bank, sel_q;
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             bank_done, rd_en;
   rd_state_t        rd_state, rd_next;
   logic [WIDTH-1:0] bank_rdata [2];

   assign bank_done = ready_o && (wr_ptr == PTR_LAST);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr  <= '0;
         wr_bank <= BANK0;
         rd_bank <= BANK0;
      end else if (bank_done) begin
         wr_ptr  <= '0;
         wr_bank <= other_bank(wr_bank);
         rd_bank <= wr_bank;
      end else if (ready_o) begin
         wr_ptr <= wr_ptr + AW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rd_state <= RD_IDLE;
      else         rd_state <= rd_next;
   end

   always_comb begin
      rd_next = rd_state;
      case (rd_state)
         RD_IDLE: if (bank_done)          rd_next = RD_BUSY;
         RD_BUSY: if (rd_ptr == PTR_LAST) rd_next = RD_IDLE;
         default:                         rd_next = RD_IDLE;
      endcase
   end

   always_comb begin
      rd_en = (rd_state == RD_BUSY);
   end

   // The output select follows the bank only on read cycles so read_data_o holds between bursts.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr         <= '0;
         sel_q          <= BANK0;
         buffer_ready_o <= 1'b0;
      end else begin
         buffer_ready_o <= rd_en;
         if (rd_en) begin
            sel_q  <= rd_bank;
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + AW'(1);
         end
      end
   end

   assign read_data_o = (sel_q == BANK1) ? bank_rdata[1] : bank_rdata[0];

   for (genvar b = 0; b < 2; b++) begin : g_bank
      localparam bank_t BANK_ID = (b == 0) ? BANK0 : BANK1;
      logic we, re;
      assign we = ready_o && (wr_bank == BANK_ID);
      assign re = rd_en && (rd_bank == BANK_ID);

      sp_ram_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .en     (we | re),
         .we     (we),
         .addr   (we ? wr_ptr : rd_ptr),
         .wdata  (ram_word),
         .rdata  (bank_rdata[b])
      );
   end

endmodule

// File: tb/tb_i2s_pingpong_capture.sv
// Self-checking bench: an I2S transmitter model drives sd_i; ready and readout streams are scoreboarded.
`timescale 1ns/1ps
module tb_i2s_pingpong_capture;

   localparam int SCK_DIV = 4;
   localparam int WIDTH   = 16;
   localparam int DEPTH   = 10;
   localparam int FRAME   = 128 * SCK_DIV;
   localparam int N_TAB   = 30;
   localparam int N_RND   = 15;
   localparam int N_POST  = 12;

   logic             clk_i  = 1'b0;
   logic             rst_ni = 1'b0;
   logic             sd_i   = 1'b0;
   logic             sck_o, ws_o, frame_start_o, ready_o, buffer_ready_o;
   logic [23:0]      left_o, right_o;
   logic [WIDTH-1:0] read_data_o;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic [23:0] l;   // drives left slot, expected on left_o
      logic [23:0] r;   // drives right slot, expected on right_o
   } frame_t;

   frame_t tab  [N_TAB];
   frame_t rnd  [N_RND];
   frame_t post [N_POST];
   frame_t tx_q [$];

   logic [WIDTH-1:0] exp_word_q [$];
   logic [WIDTH-1:0] fill_q     [$];
   logic [WIDTH-1:0] rd_exp_q   [$];

   i2s_pingpong_capture #(.SCK_DIV(SCK_DIV), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .sd_i           (sd_i),
      .sck_o          (sck_o),
      .ws_o           (ws_o),
      .frame_start_o  (frame_start_o),
      .left_o         (left_o),
      .right_o        (right_o),
      .ready_o        (ready_o),
      .read_data_o    (read_data_o),
      .buffer_ready_o (buffer_ready_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, " sck_o"},          sck_o, 0);
      check({tag, " ws_o"},           ws_o, 0);
      check({tag, " frame_start_o"},  frame_start_o, 0);
      check({tag, " left_o"},         left_o, 0);
      check({tag, " right_o"},        right_o, 0);
      check({tag, " ready_o"},        ready_o, 0);
      check({tag, " read_data_o"},    read_data_o, 0);
      check({tag, " buffer_ready_o"}, buffer_ready_o, 0);
   endtask

   // Stored word from the sample value: divide by 2^(24-WIDTH), floor or round-half-up with clamp.
   function automatic logic [WIDTH-1:0] model_word(input logic [23:0] l);
      int s;
      s = l[23] ? int'(l) - (1 << 24) : int'(l);
`ifdef I2S_PP_SAT_ROUND_EN
      s = (s + (1 << (23 - WIDTH))) >>> (24 - WIDTH);
      if (s > (1 << (WIDTH - 1)) - 1) s = (1 << (WIDTH - 1)) - 1;
`else
      s = s >>> (24 - WIDTH);
`endif
      return s[WIDTH-1:0];
   endfunction

   // Transmitter: data changes after each SCK fall, MSB one bit after the WS edge.
   logic        tx_prev_sck, tx_prev_ws, tx_started;
   int          tx_bit;
   frame_t      tx_cur;
   logic [23:0] tx_word;

   always @(negedge clk_i) begin
      if (!rst_ni) begin
         tx_prev_sck = 1'b0;
         tx_prev_ws  = 1'b0;
         tx_started  = 1'b0;
         tx_bit      = 0;
         sd_i        = 1'b0;
      end else begin
         if (tx_prev_sck && !sck_o) begin
            if (tx_prev_ws && !ws_o) begin
               tx_started = 1'b1;
               if (tx_q.size() > 0) begin
                  tx_cur = tx_q.pop_front();
               end else begin
                  tx_cur.l = 24'($urandom);
                  tx_cur.r = 24'($urandom);
               end
               exp_word_q.push_back(model_word(tx_cur.l));
            end
            tx_bit  = (tx_prev_ws != ws_o) ? 0 : tx_bit + 1;
            tx_word = ws_o ? tx_cur.r : tx_cur.l;
            if (tx_started && tx_bit >= 1 && tx_bit <= 24) sd_i = tx_word[24 - tx_bit];
            else                                           sd_i = 1'($urandom);
         end
         tx_prev_sck = sck_o;
         tx_prev_ws  = ws_o;
      end
   end

   // Scoreboard: each ready fills the bank model; a full bank becomes the expected readout burst.
   int               cyc = 0, done_cyc = 0, run = 0, bufs = 0;
   logic             prev_ready = 1'b0, prev_br = 1'b0;
   logic [WIDTH-1:0] last_word = '0;

   always @(negedge clk_i) begin
      cyc++;
      if (!rst_ni) begin
         exp_word_q.delete();
         fill_q.delete();
         rd_exp_q.delete();
         run        = 0;
         prev_ready = 1'b0;
         prev_br    = 1'b0;
      end else begin
         if (ready_o) begin
            check("ready_single_cycle", prev_ready, 0);
            check("ready_has_frame", exp_word_q.size() > 0, 1);
            if (exp_word_q.size() > 0) fill_q.push_back(exp_word_q.pop_front());
            if (fill_q.size() == DEPTH) begin
               foreach (fill_q[i]) rd_exp_q.push_back(fill_q[i]);
               fill_q.delete();
               done_cyc = cyc;
            end
         end
         if (buffer_ready_o) begin
            if (!prev_br) check("buffer_ready_latency", cyc - done_cyc, 2);
            check("readout_expected", rd_exp_q.size() > 0, 1);
            if (rd_exp_q.size() > 0) begin
               last_word = rd_exp_q.pop_front();
               check("read_data", read_data_o, last_word);
            end
            run++;
         end else if (prev_br) begin
            check("buffer_ready_run", run, DEPTH);
            check("read_data_hold", read_data_o, last_word);
            run = 0;
            bufs++;
         end
         prev_ready = ready_o;
         prev_br    = buffer_ready_o;
      end
   end

   task automatic wait_ready(output int n);
      n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (!ready_o && n < 2 * FRAME + 200);
      check("ready_seen", ready_o, 1);
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;

      for (int k = 0; k < N_TAB; k++) begin
         tab[k].l = 24'(32'h100000 + k * 32'h080000);
         tab[k].r = 24'hBAAAAA;
      end
      tab[20].l = 24'h7FFF80;   // saturates when rounding, 0x7FFF either way
      tab[21].l = 24'h000180;   // 0x0002 rounded, 0x0001 truncated
      tab[22].l = 24'h800000;
      tab[23].l = 24'hFFFFFF;
      tab[24].r = 24'h7FFFFF;
      tab[25].r = 24'h000001;
      for (int k = 0; k < N_RND; k++) begin
         rnd[k].l = 24'($urandom);
         rnd[k].r = 24'($urandom);
      end
      for (int k = 0; k < N_POST; k++) begin
         post[k].l = 24'($urandom);
         post[k].r = 24'($urandom);
      end
      foreach (tab[k]) tx_q.push_back(tab[k]);
      foreach (rnd[k]) tx_q.push_back(rnd[k]);

      repeat (10) @(negedge clk_i);
      check_outputs_zero("in_reset");
      rst_ni = 1'b1;

      @(negedge clk_i);
      check_outputs_zero("post_release");
      n = 1;
      while (!frame_start_o && n < 2000) begin
         @(negedge clk_i);
         check("no_ready_before_first_frame", ready_o, 0);
         n++;
      end
      check("first_ws_fall_cycle", n, FRAME);
      check("ws_low_at_frame_start", ws_o, 0);

      for (int i = 0; i < N_TAB; i++) begin
         wait_ready(n);
         if (i == 0) check("first_ready_within_frame", n <= FRAME, 1);
         else        check("ready_period", n, FRAME);
         check("left_o", left_o, tab[i].l);
         check("right_o", right_o, tab[i].r);
      end

      for (int i = 0; i < N_RND; i++) begin
         wait_ready(n);
         check("ready_period_rnd", n, FRAME);
         check("left_o_rnd", left_o, rnd[i].l);
         check("right_o_rnd", right_o, rnd[i].r);
      end
      check("buffers_before_reset", bufs, (N_TAB + N_RND) / DEPTH);

      // Half-filled bank (sample 5 of 10) is abandoned by an asynchronous reset.
      rst_ni = 1'b0;
      #1;
      check_outputs_zero("async_reset");
      repeat (10) @(negedge clk_i);
      tx_q.delete();
      foreach (post[k]) tx_q.push_back(post[k]);
      bufs   = 0;
      rst_ni = 1'b1;

      for (int i = 0; i < N_POST; i++) begin
         wait_ready(n);
         if (i == 0) check("first_ready_after_reset", (n > FRAME) && (n <= 2 * FRAME), 1);
         else        check("ready_period_post", n, FRAME);
         check("left_o_post", left_o, post[i].l);
         check("right_o_post", right_o, post[i].r);
      end
      repeat (DEPTH + 5) @(negedge clk_i);
      check("buffers_after_reset", bufs, 1);
      check("readout_queue_drained", rd_exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
